// File: rtl/param_edge_bit_counter.sv
// Oversampled serial-frame timing: counts edges within a bit and bits within a frame.
// Strobes decode registered state combinationally; CfgErr is registered one cycle after the illegal sample.
module param_edge_bit_counter #(
  parameter int PS_W = 6,
  parameter int BC_W = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Enable,
  input  logic            Clear,
  input  logic [PS_W-1:0] Prescale,
  input  logic [3:0]      DataWidth,
  input  logic            ParityEn,
  input  logic            StopBits2,
  output logic [PS_W-1:0] EdgeCounter,
  output logic [BC_W-1:0] BitCounter,
  output logic            SampleStrobe,
  output logic            BitDone,
  output logic            FrameDone,
  output logic            Busy,
  output logic            CfgErr
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PS_W-1:0] r_edge;
  logic [PS_W-1:0] w_edge_nxt;
  logic [BC_W-1:0] r_bit;
  logic [BC_W-1:0] w_bit_nxt;
  logic [PS_W-1:0] r_ps;
  logic [3:0]      r_dw;
  logic            r_par;
  logic            r_stop2;
  logic            r_cfg_err;
  logic            w_cfg_err_nxt;
  logic            w_latch;
  logic            w_cfg_ok;
  logic [PS_W-1:0] w_ps_m1;
  logic [PS_W-1:0] w_half;
  logic [4:0]      w_last_full;
  logic [BC_W-1:0] w_last_bit;
  logic            w_is_count;
  logic            w_bit_end;
  logic            w_frame_end;
  logic            w_mid;

  assign w_cfg_ok = ((Prescale == PS_W'(8)) || (Prescale == PS_W'(16)) || (Prescale == PS_W'(32)))
                    && (DataWidth >= 4'd5) && (DataWidth <= 4'd9);

  // Index of the last bit: N-1 = DataWidth + ParityEn + 1 + StopBits2.
  assign w_last_full = 5'd1 + {1'b0, r_dw} + {4'b0, r_par} + {4'b0, r_stop2};
  assign w_last_bit  = BC_W'(w_last_full);

  assign w_ps_m1     = r_ps - PS_W'(1);
  assign w_half      = r_ps >> 1;
  assign w_is_count  = (r_state == COUNT);
  assign w_bit_end   = w_is_count && (r_edge == w_ps_m1);
  assign w_frame_end = w_bit_end && (r_bit == w_last_bit);
  assign w_mid       = (r_edge == (w_half - PS_W'(1))) || (r_edge == w_half) ||
                       (r_edge == (w_half + PS_W'(1)));

  always_comb begin
    w_state_nxt   = r_state;
    w_edge_nxt    = r_edge;
    w_bit_nxt     = r_bit;
    w_latch       = 1'b0;
    w_cfg_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_edge_nxt = '0;
        w_bit_nxt  = '0;
        if (!Clear && Enable) begin
          if (w_cfg_ok) begin
            w_latch     = 1'b1;
            w_state_nxt = COUNT;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      COUNT: begin
        // Clear, abort and frame completion all collapse to the same exit.
        if (Clear || !Enable || w_frame_end) begin
          w_state_nxt = IDLE;
          w_edge_nxt  = '0;
          w_bit_nxt   = '0;
        end else if (w_bit_end) begin
          w_edge_nxt = '0;
          w_bit_nxt  = r_bit + BC_W'(1);
        end else begin
          w_edge_nxt = r_edge + PS_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_edge_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_edge    <= '0;
      r_bit     <= '0;
      r_ps      <= PS_W'(8);
      r_dw      <= 4'd8;
      r_par     <= 1'b0;
      r_stop2   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_edge    <= w_edge_nxt;
      r_bit     <= w_bit_nxt;
      r_cfg_err <= w_cfg_err_nxt;
      if (w_latch) begin
        r_ps    <= Prescale;
        r_dw    <= DataWidth;
        r_par   <= ParityEn;
        r_stop2 <= StopBits2;
      end
    end
  end

  assign EdgeCounter  = r_edge;
  assign BitCounter   = r_bit;
  assign Busy         = w_is_count;
  assign BitDone      = w_bit_end;
  assign FrameDone    = w_frame_end;
  assign SampleStrobe = w_is_count && w_mid;
  assign CfgErr       = r_cfg_err;

endmodule

// File: tb/tb_param_edge_bit_counter.sv
// Randomized bench: a frame-cycle-index reference model feeds a queue that a monitor drains each cycle.
module tb_param_edge_bit_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Enable = 1'b0;
  logic       Clear = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [3:0] DataWidth = 4'd8;
  logic       ParityEn = 1'b0;
  logic       StopBits2 = 1'b0;
  logic [5:0] EdgeCounter;
  logic [3:0] BitCounter;
  logic       SampleStrobe, BitDone, FrameDone, Busy, CfgErr;

  param_edge_bit_counter #(.PS_W(6), .BC_W(4)) dut (
    .CLK(CLK), .RST(RST), .Enable(Enable), .Clear(Clear), .Prescale(Prescale),
    .DataWidth(DataWidth), .ParityEn(ParityEn), .StopBits2(StopBits2),
    .EdgeCounter(EdgeCounter), .BitCounter(BitCounter), .SampleStrobe(SampleStrobe),
    .BitDone(BitDone), .FrameDone(FrameDone), .Busy(Busy), .CfgErr(CfgErr)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0] ec;
    logic [3:0] bc;
    logic       ss;
    logic       bd;
    logic       fd;
    logic       busy;
    logic       ce;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  int fd_cnt = 0, bd_cnt = 0, busy_cnt = 0, ss_cnt = 0, ce_cnt = 0;

  // Reference model: a frame is N*P consecutive COUNT cycles indexed by k.
  bit m_busy = 1'b0;
  int m_k = 0;
  int m_p = 8;
  int m_n = 10;
  bit m_ce = 1'b0;

  task automatic cyc(input logic rst, input logic en, input logic clr, input logic [5:0] ps,
                     input logic [3:0] dw, input logic par, input logic s2);
    exp_t e;
    int ph;
    bit legal;
    @(negedge CLK);
    cyc_no++;
    ph     = m_k % m_p;
    e.busy = m_busy;
    e.ec   = m_busy ? 6'(ph) : 6'd0;
    e.bc   = m_busy ? 4'(m_k / m_p) : 4'd0;
    e.bd   = m_busy && (ph == m_p - 1);
    e.ss   = m_busy && (ph >= m_p / 2 - 1) && (ph <= m_p / 2 + 1);
    e.fd   = m_busy && (m_k == m_n * m_p - 1);
    e.ce   = m_ce;
    exp_q.push_back(e);
    RST = rst; Enable = en; Clear = clr; Prescale = ps; DataWidth = dw; ParityEn = par; StopBits2 = s2;
    legal = (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) && (dw >= 4'd5) && (dw <= 4'd9);
    if (rst) begin
      m_busy = 1'b0; m_k = 0; m_p = 8; m_n = 10; m_ce = 1'b0;
    end else begin
      m_ce = !m_busy && en && !clr && !legal;
      if (m_busy) begin
        if (clr || !en || (m_k == m_n * m_p - 1)) begin
          m_busy = 1'b0; m_k = 0;
        end else begin
          m_k++;
        end
      end else if (en && !clr && legal) begin
        m_busy = 1'b1; m_k = 0; m_p = int'(ps);
        m_n = 1 + int'(dw) + int'(par) + (s2 ? 2 : 1);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{EdgeCounter, BitCounter, SampleStrobe, BitDone, FrameDone, Busy, CfgErr};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got ec=%0d bc=%0d ss=%b bd=%b fd=%b busy=%b ce=%b, want ec=%0d bc=%0d ss=%b bd=%b fd=%b busy=%b ce=%b",
                   cyc_no, a.ec, a.bc, a.ss, a.bd, a.fd, a.busy, a.ce,
                   e.ec, e.bc, e.ss, e.bd, e.fd, e.busy, e.ce);
        end
        fd_cnt   += int'(FrameDone);
        bd_cnt   += int'(BitDone);
        busy_cnt += int'(Busy);
        ss_cnt   += int'(SampleStrobe);
        ce_cnt   += int'(CfgErr);
      end
    end
  end

  task automatic drain_and_clear();
    #2;
    fd_cnt = 0; bd_cnt = 0; busy_cnt = 0; ss_cnt = 0; ce_cnt = 0;
  endtask

  task automatic drain();
    #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin : stim
    logic [5:0] ps_v;
    logic [3:0] dw_v;
    logic       par_v, s2_v, en_v, rst_v, clr_v;

    repeat (3) cyc(1, 0, 0, 6'd8, 4'd8, 0, 0);
    cyc(0, 0, 0, 6'd8, 4'd8, 0, 0);
    drain_and_clear();

    // P=8, 8N1: ten bits of eight edges.
    repeat (81) cyc(0, 1, 0, 6'd8, 4'd8, 0, 0);
    repeat (2) cyc(0, 0, 0, 6'd8, 4'd8, 0, 0);
    drain();
    chk("8N1 busy cycles", busy_cnt, 80);
    chk("8N1 frame done", fd_cnt, 1);
    chk("8N1 bit done", bd_cnt, 10);
    drain_and_clear();

    // P=16, 7 data, parity, two stop bits.
    repeat (177) cyc(0, 1, 0, 6'd16, 4'd7, 1, 1);
    repeat (2) cyc(0, 0, 0, 6'd16, 4'd7, 1, 1);
    drain();
    chk("7P2 busy cycles", busy_cnt, 176);
    chk("7P2 bit done", bd_cnt, 11);
    chk("7P2 sample strobes", ss_cnt, 33);
    chk("7P2 frame done", fd_cnt, 1);
    drain_and_clear();

    // Prescale switches to 32 mid-frame; latched P=8 must persist.
    repeat (30) cyc(0, 1, 0, 6'd8, 4'd8, 0, 0);
    repeat (51) cyc(0, 1, 0, 6'd32, 4'd8, 0, 0);
    repeat (2) cyc(0, 0, 0, 6'd32, 4'd8, 0, 0);
    drain();
    chk("cfg change busy cycles", busy_cnt, 80);
    chk("cfg change frame done", fd_cnt, 1);
    drain_and_clear();

    // Abort at bit 4, edge 3.
    repeat (36) cyc(0, 1, 0, 6'd8, 4'd8, 0, 0);
    repeat (3) cyc(0, 0, 0, 6'd8, 4'd8, 0, 0);
    drain();
    chk("abort busy cycles", busy_cnt, 36);
    chk("abort frame done", fd_cnt, 0);
    drain_and_clear();

    // Illegal prescale, then Clear masking the same request.
    repeat (5) cyc(0, 1, 0, 6'd12, 4'd8, 0, 0);
    cyc(0, 0, 0, 6'd12, 4'd8, 0, 0);
    drain();
    chk("illegal cfg errors", ce_cnt, 5);
    chk("illegal cfg busy", busy_cnt, 0);
    drain_and_clear();
    repeat (4) cyc(0, 1, 1, 6'd12, 4'd8, 0, 0);
    repeat (3) cyc(0, 1, 1, 6'd8, 4'd8, 0, 0);
    repeat (2) cyc(0, 0, 0, 6'd8, 4'd8, 0, 0);
    drain();
    chk("clear masks cfg error", ce_cnt, 0);
    chk("clear blocks start", busy_cnt, 0);
    drain_and_clear();

    // Reset mid-frame at bit 6, then a clean frame.
    repeat (50) cyc(0, 1, 0, 6'd8, 4'd8, 0, 0);
    cyc(1, 1, 0, 6'd8, 4'd8, 0, 0);
    repeat (81) cyc(0, 1, 0, 6'd8, 4'd8, 0, 0);
    repeat (2) cyc(0, 0, 0, 6'd8, 4'd8, 0, 0);
    drain();
    chk("reset recovery frame done", fd_cnt, 1);
    drain_and_clear();

    // Random traffic with occasional illegal configs, aborts, clears and resets.
    ps_v = 6'd8; dw_v = 4'd8; par_v = 1'b0; s2_v = 1'b0; en_v = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: ps_v = 6'd8;
          3, 4, 5: ps_v = 6'd16;
          6, 7, 8: ps_v = 6'd32;
          default: ps_v = 6'($urandom_range(0, 63));
        endcase
        dw_v  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 9));
        par_v = 1'($urandom_range(0, 1));
        s2_v  = 1'($urandom_range(0, 1));
      end
      if (en_v) en_v = ($urandom_range(0, 149) != 0);
      else      en_v = ($urandom_range(0, 2) == 0);
      rst_v = ($urandom_range(0, 199) == 0);
      clr_v = ($urandom_range(0, 99) == 0);
      cyc(rst_v, en_v, clr_v, ps_v, dw_v, par_v, s2_v);
    end
    cyc(0, 0, 0, 6'd8, 4'd8, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_edge_bit_counter.md
PARAM_EDGE_BIT_COUNTER -- requirements
Module: param_edge_bit_counter

Interface
REQ-001 SHALL have parameter PS_W, default 6, meaning edge-counter width; it supports a prescale of up to 32.
REQ-002 SHALL have parameter BC_W, default 4, meaning bit-counter width; it supports frames of up to 13 bits.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port Enable  input  1  frame reception active; low = abort.
REQ-006 SHALL have port Clear  input  1  synchronous restart request.
REQ-007 SHALL have port Prescale  input  PS_W  oversampling ratio; legal values 8, 16, 32.
REQ-008 SHALL have port DataWidth  input  4  data bits per frame; legal values 5..9.
REQ-009 SHALL have port ParityEn  input  1  a parity bit follows the data.
REQ-010 SHALL have port StopBits2  input  1  two stop bits when 1, one stop bit when 0.
REQ-011 SHALL have port EdgeCounter  output  PS_W  edge index within the current bit.
REQ-012 SHALL have port BitCounter  output  BC_W  bit index within the frame; start bit = 0.
REQ-013 SHALL have port SampleStrobe  output  1  marks the three mid-bit sample edges.
REQ-014 SHALL have port BitDone  output  1  marks the last edge of the current bit.
REQ-015 SHALL have port FrameDone  output  1  marks the last edge of the last bit.
REQ-016 SHALL have port Busy  output  1  FSM is in COUNT.
REQ-017 SHALL have port CfgErr  output  1  one-cycle pulse on an illegal configuration.

Function
REQ-018 SHALL implement two FSM states, IDLE and COUNT.
REQ-019 SHALL, in IDLE, hold EdgeCounter=0 and BitCounter=0 and keep Busy, SampleStrobe, BitDone and FrameDone at 0.
REQ-020 SHALL, in IDLE with Enable=1 and Clear=0 and a legal configuration, latch Prescale/DataWidth/ParityEn/StopBits2, move to COUNT with both counters 0, and set Busy=1 from the next cycle.
REQ-021 SHALL, in IDLE with Enable=1 and an illegal configuration (Prescale not in {8,16,32} or DataWidth not in 5..9), pulse CfgErr for 1 cycle, stay in IDLE, and re-evaluate every cycle.
REQ-022 SHALL ignore configuration input changes during COUNT; only the latched copy is used.
REQ-023 SHALL compute frame length as N = 1 + DataWidth + ParityEn + (StopBits2 ? 2 : 1), in the range 7..13, with no overflow at BC_W=4.
REQ-024 SHALL, in COUNT with Enable=1, increment EdgeCounter each cycle, where P is the latched Prescale.
REQ-025 SHALL, when EdgeCounter==P-1, set EdgeCounter to 0 and increment BitCounter.
REQ-026 SHALL drive BitDone = COUNT and EdgeCounter==P-1 (combinational decode of registered state).
REQ-027 SHALL drive SampleStrobe = COUNT and EdgeCounter in {P/2-1, P/2, P/2+1}; for P=8 these are edges 3, 4, 5.
REQ-028 SHALL drive FrameDone = BitDone and BitCounter==N-1.
REQ-029 SHALL, on the edge ending a FrameDone cycle, return to IDLE with both counters 0.
REQ-030 SHALL require Enable to fall and rise again, or stay high, before the next frame; with Enable held high, re-entry to COUNT occurs the cycle after IDLE.
REQ-031 SHALL treat Enable=0 in COUNT as an abort: next state IDLE, counters 0, and no FrameDone.
REQ-032 SHALL give Clear=1 in any state the same effect as an abort; Clear has priority over Enable.
REQ-033 SHALL, when Clear=1 and Enable=1 in IDLE, stay in IDLE with no CfgErr.
REQ-034 SHALL apply the priority order RST > Clear > Enable-abort > counting.
REQ-035 SHALL never let EdgeCounter exceed P-1 nor BitCounter exceed N-1 in any state.

Reset
REQ-036 SHALL, with RST=1 at a rising CLK edge, set state to IDLE, clear EdgeCounter and BitCounter, clear the latched configuration to Prescale=8, DataWidth=8, ParityEn=0, StopBits2=0, and drive all pulse outputs to 0.
REQ-037 SHALL, on reset asserted mid-frame, take effect at the next edge; the first frame after reset release starts no earlier than 1 cycle after RST falls.

Verification
REQ-038 SHALL cover: P=8, DataWidth=8, ParityEn=0, StopBits2=0, Enable high -> N=10, 80 COUNT cycles, FrameDone once at BitCounter=9 and EdgeCounter=7, then IDLE.
REQ-039 SHALL cover: P=16, DataWidth=7, ParityEn=1, StopBits2=1 -> N=11, SampleStrobe at edges 7, 8, 9 of every bit, 11 BitDone pulses, 176 COUNT cycles.
REQ-040 SHALL cover: Prescale changed from 8 to 32 mid-frame -> no effect; the frame completes at P=8.
REQ-041 SHALL cover: Enable dropped at BitCounter=4, EdgeCounter=3 -> IDLE next cycle, counters 0, no FrameDone.
REQ-042 SHALL cover: Prescale=12 with Enable=1 -> CfgErr pulses each cycle, Busy stays 0; and Clear=1 concurrent with Enable=1 -> no CfgErr.
REQ-043 SHALL cover: RST=1 at BitCounter=6 -> all outputs 0 after the next edge; a legal frame afterwards completes normally.
